// File: rtl/rv32_pkg.sv
// Shared encodings and helpers for the iterative divider.
// Holds op codes, FSM state encoding and the special-case result rules.
package rv32_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_STEPS = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    // Divide-by-zero and signed overflow have fixed architectural results.
    function automatic logic is_special(input logic [1:0] op, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
        return (b == '0) || (op_is_signed(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1));
    endfunction

    function automatic logic [XLEN-1:0] special_result(input logic [1:0] op,
                                                       input logic [XLEN-1:0] a,
                                                       input logic [XLEN-1:0] b);
        if (b == '0)
            return op_is_rem(op) ? a : '1;
        return op_is_rem(op) ? '0 : a;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial subtract,
// and emit the quotient bit.
module div_step
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {1'b0, div_i};
        // A set top bit means the trial went negative: restore.
        if (trial[XLEN]) begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o = trial[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider (IDLE -> CALC x32 -> FIX -> DONE).
// Define DIV_FAST_PATH_EN to send divide-by-zero and signed overflow straight to DONE.
module div_unit
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

    div_state_e      state_q, state_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] step_rem, step_quo;
    logic            quo_neg, rem_neg;

    div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign quo_neg = op_is_signed(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    assign rem_neg = op_is_signed(op_q) && a_q[XLEN-1];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    rem_d   = '0;
                    quo_d   = magnitude(a, op_is_signed(op));
                    dvs_d   = magnitude(b, op_is_signed(op));
                    cnt_d   = '0;
                    state_d = S_CALC;
`ifdef DIV_FAST_PATH_EN
                    if (is_special(op, a, b)) begin
                        result_d = special_result(op, a, b);
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == LAST_STEP)
                    state_d = S_FIX;
                else
                    cnt_d = cnt_q + 6'd1;
            end
            S_FIX: begin
                if (is_special(op_q, a_q, b_q))
                    result_d = special_result(op_q, a_q, b_q);
                else if (op_is_rem(op_q))
                    result_d = rem_neg ? -rem_q : rem_q;
                else
                    result_d = quo_neg ? -quo_q : quo_q;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // An aborted operation must leave the visible result untouched.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed scoreboard bench for div_unit: expected results and done cycles are
// queued at issue time and checked by an independent monitor on done.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef DIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    string       name_q[$];
    int          checks = 0;
    int          passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic int latency(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        bit special;
        special = (bv == 32'd0) || ((o == 2'b00 || o == 2'b10) && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF);
        return (FAST && special) ? 0 : 33;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                string nm;
                nm = name_q.pop_front();
                chk({nm, "_result"}, result, exp_q.pop_front());
                chk({nm, "_done_cycle"}, cyc, exp_cyc_q.pop_front());
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + latency(o, av, bv));
        name_q.push_back(name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk({name, "_timeout"}, 32'd1, 32'd0);
            exp_q.delete(); exp_cyc_q.delete(); name_q.delete();
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[] = '{
        '{"div_100_7",      2'b00, 32'd100,        32'd7,         32'd14},
        '{"rem_100_7",      2'b10, 32'd100,        32'd7,         32'd2},
        '{"div_m100_7",     2'b00, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2},
        '{"rem_m100_7",     2'b10, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE},
        '{"divu_max_2",     2'b01, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF},
        '{"divu_5_0",       2'b01, 32'd5,          32'd0,         32'hFFFF_FFFF},
        '{"remu_5_0",       2'b11, 32'd5,          32'd0,         32'd5},
        '{"div_ovf",        2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
        '{"rem_ovf",        2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
        '{"div_5_0",        2'b00, 32'd5,          32'd0,         32'hFFFF_FFFF},
        '{"rem_m7_0",       2'b10, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9},
        '{"div_7_m2",       2'b00, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD},
        '{"rem_7_m2",       2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1},
        '{"divu_min_3",     2'b01, 32'h8000_0000,  32'd3,         32'h2AAA_AAAA},
        '{"remu_100_7",     2'b11, 32'd100,        32'd7,         32'd2}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, 32'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            wait_idle(vecs[i].name);
        end

        // Start while busy is ignored; operands stay latched.
        issue("busy_start", 2'b00, 32'd100, 32'd7, 32'd14);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd4;
        @(posedge clk); #1 start = 1'b0;
        wait_idle("busy_start");

        // Flush mid-CALC aborts with no done; a later start completes.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        @(negedge clk);
        issue("after_flush", 2'b01, 32'd1000, 32'd3, 32'd333);
        wait_idle("after_flush");

        // Flush and start together: nothing accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("flush_start_idle", busy, 1'b0);

        // Start coinciding with done is dropped.
        issue("done_start", 2'b00, 32'd50, 32'd5, 32'd10);
        begin
            int n = 0;
            while (done !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("done_start_seen", done, 1'b1);
        end
        start = 1'b1; op = 2'b01; a = 32'd8; b = 32'd2;
        @(posedge clk); #1 start = 1'b0;
        chk("done_start_busy", busy, 1'b0);
        wait_idle("done_start");

        // Reset mid-CALC clears everything and produces no done.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd77; b = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_done", done, 1'b0);
        chk("midreset_result", result, 32'd0);
        repeat (40) @(negedge clk);
        issue("after_reset", 2'b01, 32'd77, 32'd7, 32'd11);
        wait_idle("after_reset");

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
